tbs_tx: RTL and testbench
=========================

Name: tbs_tx

Overview:
- RS-232-to-TBS bridge: receives 8N1 UART bytes on rs232_in and re-transmits each valid byte as one Manchester-coded TBS frame on TBS_out.
- Sits between a host serial link and the transducer/board TBS control line.
- Single clock domain: clk_50M. No host handshake; all flow control is internal.

Parameters:
- CLK_FREQ, 50_000_000, clk_50M frequency in Hz.
- BAUD_RATE, 115200, UART bit rate. Divisor BAUD_DIV = CLK_FREQ/BAUD_RATE, integer-truncated (434 at defaults).
- TBS_HALF_CYCLES, 50, clk_50M cycles per Manchester half-bit. One TBS bit = 2*TBS_HALF_CYCLES = 100 cycles = 2 us.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- rs232_in  in  1  UART RX line; idle high, asynchronous to clk_50M.
- TBS_out  out  1  TBS serial output; idle high; registered.

Behaviour:
- Reset: TBS_out=1; RX FSM in R_IDLE; TX FSM in T_IDLE; holding buffer empty. Asserting reset mid-frame forces TBS_out=1 immediately (async) and discards all data.
- Input sync: rs232_in passes through a 2-FF synchroniser, preset to 1 on reset. All RX logic uses the synchronised signal.
- RX FSM:
  - R_IDLE: a synchronised falling edge loads the baud counter with BAUD_DIV/2 and moves to R_START.
  - R_START: at mid start bit, if the line is high the edge was a glitch; return to R_IDLE with nothing stored. Otherwise go to R_DATA.
  - R_DATA: sample 8 bits, one every BAUD_DIV cycles at bit centres, LSB first.
  - R_STOP: sample the stop bit. If 1, the byte is valid. If 0 (framing error), discard the byte. Either way return to R_IDLE.
- Buffer: one-byte holding register plus a full flag.
  - A valid byte is written on the stop-sample cycle.
  - If the buffer is already full, the new byte is dropped and the older byte is kept.
  - The TX FSM clears the flag when it loads the byte into its shift register.
- TX FSM:
  - T_IDLE: TBS_out=1. When the buffer is full, load the shift register, clear the flag, and go to T_SYNC.
  - T_SYNC: TBS_out=0 for 2 TBS bits (200 cycles).
  - T_DATA: 8 bits, MSB first, Manchester coded. Bit 0 = high half then low half; bit 1 = low half then high half. Each half lasts TBS_HALF_CYCLES.
  - T_GUARD: TBS_out=1 for 1 TBS bit (100 cycles), then go to T_IDLE.
- Frame length: 11 TBS bits = 1100 cycles = 22 us. A UART byte takes about 86.8 us, so back-to-back bytes never overflow the buffer at default settings.
- Latency: TBS_out falls exactly 2 clk_50M cycles after the stop-bit sample cycle. That is 1 cycle to the T_SYNC transition plus 1 output register stage.
- Simultaneous events: a buffer write and a TX load in the same cycle never coincide, because the write fires on the stop sample and the load happens 1 cycle later. A new byte arriving during T_DATA or T_GUARD waits in the buffer. The next frame starts in the cycle after T_GUARD ends, with no extra idle time.
- Counters: baud counter and half-bit counter are sized to $clog2 of their maximum value. Counters wrap only through explicit reload, never by overflow.

Optional Feature:
- Macro: TBS_PARITY_EN.
- Defined: a state T_PARITY is inserted between T_DATA and T_GUARD. It sends one Manchester-coded even-parity bit (XOR of the 8 data bits). Frame becomes 12 TBS bits = 1200 cycles; latency is unchanged.
- Undefined: no parity bit is sent; frame is 11 TBS bits; T_PARITY does not exist.

Test Plan:
- Reset: hold rst_n=0 for 200 ns with rs232_in=1 -> TBS_out=1 throughout. TBS_out stays 1 for 10 us after release.
- Send 0x55 (8N1, 8680 ns/bit) -> TBS_out falls 2 cycles after the stop-bit centre, stays low 200 cycles, then carries half-bits H,L,L,H repeated 4 times (MSB 0 first). It then stays high 100 cycles; total frame 1100 cycles.
- Send 0xA3, 0x00, 0xFF in sequence with a 20-bit gap -> three frames, in order. 0x00 gives 8 "HL" pairs; 0xFF gives 8 "LH" pairs; no frame is lost.
- Glitch: pulse rs232_in low for 2 us -> R_START rejects it and TBS_out stays 1. A corrupt stop bit (stop=0 on 0x6B) -> no frame is produced.
- Reset mid-frame: assert rst_n=0 during T_DATA -> TBS_out=1 within the same cycle, with no residual frame after release. With TBS_PARITY_EN defined, 0x0B (3 ones) -> parity bit 1 sent as "LH" before the guard.

Source files
------------

// File: rtl/tbs_tx.sv
`timescale 1ns/1ps
// tbs_tx: RS-232 (8N1) receiver feeding a Manchester-coded TBS frame transmitter.
// Each valid UART byte becomes one TBS frame: 2 sync bits low, 8 data bits
// MSB first (0 = high/low, 1 = low/high), 1 guard bit high.
// Optional feature macro TBS_PARITY_EN: adds one Manchester even-parity bit
// between the data and the guard bit.
// Ports:
//   clk_50M  - system clock
//   rst_n    - asynchronous active-low reset
//   rs232_in - UART RX line, idle high, asynchronous to clk_50M
//   TBS_out  - TBS serial output, idle high, registered
module tbs_tx #(
   parameter int unsigned CLK_FREQ        = 50_000_000,
   parameter int unsigned BAUD_RATE       = 115200,
   parameter int unsigned TBS_HALF_CYCLES = 50
) (
   input  logic clk_50M,
   input  logic rst_n,
   input  logic rs232_in,
   output logic TBS_out
);

   localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE;
   localparam int unsigned BAUD_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned HALF_W    = (TBS_HALF_CYCLES > 2) ? $clog2(TBS_HALF_CYCLES) : 1;
   localparam int unsigned IDX_W     = 4;
   localparam logic [BAUD_W-1:0] BAUD_MID    = BAUD_W'(BAUD_DIV / 2);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(TBS_HALF_CYCLES - 1);

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      T_IDLE,
      T_SYNC,
      T_DATA,
`ifdef TBS_PARITY_EN
      T_PARITY,
`endif
      T_GUARD
   } tx_state_t;

   // ------------------------------------------------------------------
   // Input synchroniser and falling-edge detect (preset to idle level)
   // ------------------------------------------------------------------
   logic [1:0] rx_sync;
   logic       rx_prev;
   logic       rx;
   logic       rx_fall;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], rs232_in};
         rx_prev <= rx_sync[1];
      end
   end

   assign rx      = rx_sync[1];
   assign rx_fall = rx_prev & ~rx;

   // ------------------------------------------------------------------
   // RX FSM: state register and datapath
   // ------------------------------------------------------------------
   rx_state_t         rx_state, rx_state_nxt;
   logic [BAUD_W-1:0] baud_cnt, baud_cnt_nxt;
   logic [2:0]        bit_cnt, bit_cnt_nxt;
   logic [7:0]        rx_shift, rx_shift_nxt;
   logic              baud_tick;
   logic              buf_wr;

   logic [7:0]        buf_data;
   logic              buf_full;
   logic              tx_load;

   assign baud_tick = (baud_cnt == '0);

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= R_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_cnt  <= bit_cnt_nxt;
         rx_shift <= rx_shift_nxt;
      end
   end

   // RX next-state: counter runs down to zero at each bit centre, then reloads
   always_comb begin
      rx_state_nxt = rx_state;
      baud_cnt_nxt = baud_cnt;
      bit_cnt_nxt  = bit_cnt;
      rx_shift_nxt = rx_shift;
      buf_wr       = 1'b0;

      case (rx_state)
         R_IDLE: begin
            if (rx_fall) begin
               baud_cnt_nxt = BAUD_MID;
               rx_state_nxt = R_START;
            end
         end
         R_START: begin
            if (!baud_tick) begin
               baud_cnt_nxt = baud_cnt - BAUD_W'(1);
            end else if (rx) begin
               // line back high at mid start bit: glitch, not a start bit
               rx_state_nxt = R_IDLE;
            end else begin
               baud_cnt_nxt = BAUD_RELOAD;
               bit_cnt_nxt  = '0;
               rx_state_nxt = R_DATA;
            end
         end
         R_DATA: begin
            if (!baud_tick) begin
               baud_cnt_nxt = baud_cnt - BAUD_W'(1);
            end else begin
               rx_shift_nxt = {rx, rx_shift[7:1]};
               baud_cnt_nxt = BAUD_RELOAD;
               bit_cnt_nxt  = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  bit_cnt_nxt  = '0;
                  rx_state_nxt = R_STOP;
               end
            end
         end
         R_STOP: begin
            if (!baud_tick) begin
               baud_cnt_nxt = baud_cnt - BAUD_W'(1);
            end else begin
               // framing error or full buffer: byte is dropped
               buf_wr       = rx & ~buf_full;
               rx_state_nxt = R_IDLE;
            end
         end
         default: rx_state_nxt = R_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // One-byte holding buffer between RX and TX
   // ------------------------------------------------------------------
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         buf_data <= '0;
         buf_full <= 1'b0;
      end else if (buf_wr) begin
         buf_data <= rx_shift;
         buf_full <= 1'b1;
      end else if (tx_load) begin
         buf_full <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // TX FSM: state register and datapath
   // ------------------------------------------------------------------
   tx_state_t         tx_state, tx_state_nxt;
   logic [HALF_W-1:0] half_cnt, half_cnt_nxt;
   logic [IDX_W-1:0]  half_idx, half_idx_nxt;
   logic [7:0]        tx_shift;
   logic              tx_shift_en;
   logic              out_nxt;
   logic              half_end;

`ifdef TBS_PARITY_EN
   logic              par_bit;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         par_bit <= 1'b0;
      end else if (tx_load) begin
         par_bit <= ^buf_data;
      end
   end
`endif

   assign half_end = (half_cnt == HALF_LAST);

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= T_IDLE;
         half_cnt <= '0;
         half_idx <= '0;
         tx_shift <= '0;
         TBS_out  <= 1'b1;
      end else begin
         tx_state <= tx_state_nxt;
         half_cnt <= half_cnt_nxt;
         half_idx <= half_idx_nxt;
         TBS_out  <= out_nxt;
         if (tx_load) begin
            tx_shift <= buf_data;
         end else if (tx_shift_en) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
         end
      end
   end

   // TX next-state: the output level is computed for the next state so the
   // registered TBS_out lines up with the state it belongs to.
   always_comb begin
      tx_state_nxt = tx_state;
      half_cnt_nxt = half_end ? '0 : half_cnt + HALF_W'(1);
      half_idx_nxt = half_idx;
      out_nxt      = TBS_out;
      tx_load      = 1'b0;
      tx_shift_en  = 1'b0;

      case (tx_state)
         T_IDLE: begin
            half_cnt_nxt = '0;
            out_nxt      = 1'b1;
            if (buf_full) begin
               tx_load      = 1'b1;
               half_idx_nxt = '0;
               out_nxt      = 1'b0;
               tx_state_nxt = T_SYNC;
            end
         end
         T_SYNC: begin
            out_nxt = 1'b0;
            if (half_end) begin
               half_idx_nxt = half_idx + IDX_W'(1);
               if (half_idx == IDX_W'(3)) begin
                  half_idx_nxt = '0;
                  out_nxt      = ~tx_shift[7];
                  tx_state_nxt = T_DATA;
               end
            end
         end
         T_DATA: begin
            if (half_end) begin
               half_idx_nxt = half_idx + IDX_W'(1);
               if (!half_idx[0]) begin
                  // second half of a bit carries the bit value itself
                  out_nxt = tx_shift[7];
               end else begin
                  tx_shift_en = 1'b1;
                  if (half_idx == IDX_W'(15)) begin
                     half_idx_nxt = '0;
`ifdef TBS_PARITY_EN
                     out_nxt      = ~par_bit;
                     tx_state_nxt = T_PARITY;
`else
                     out_nxt      = 1'b1;
                     tx_state_nxt = T_GUARD;
`endif
                  end else begin
                     out_nxt = ~tx_shift[6];
                  end
               end
            end
         end
`ifdef TBS_PARITY_EN
         T_PARITY: begin
            if (half_end) begin
               if (!half_idx[0]) begin
                  half_idx_nxt = half_idx + IDX_W'(1);
                  out_nxt      = par_bit;
               end else begin
                  half_idx_nxt = '0;
                  out_nxt      = 1'b1;
                  tx_state_nxt = T_GUARD;
               end
            end
         end
`endif
         T_GUARD: begin
            out_nxt = 1'b1;
            if (half_end) begin
               if (half_idx == '0) begin
                  half_idx_nxt = IDX_W'(1);
               end else if (buf_full) begin
                  // a waiting byte starts its frame with no idle gap
                  tx_load      = 1'b1;
                  half_idx_nxt = '0;
                  out_nxt      = 1'b0;
                  tx_state_nxt = T_SYNC;
               end else begin
                  half_idx_nxt = '0;
                  tx_state_nxt = T_IDLE;
               end
            end
         end
         default: begin
            out_nxt      = 1'b1;
            tx_state_nxt = T_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tbs_tx.sv
`timescale 1ns/1ps
// tb_tbs_tx: directed bench for tbs_tx. A vector table of UART bytes with
// hand-computed Manchester half-bit patterns drives the main checks; short
// hand-written sequences cover reset, glitch rejection and mid-frame reset.
module tb_tbs_tx;

   localparam int BIT_NS = 8680;
   localparam int HALF   = 50;
`ifdef TBS_PARITY_EN
   localparam int FRAME  = 1200;
`else
   localparam int FRAME  = 1100;
`endif
   localparam int NVEC   = 7;

   logic clk_50M = 1'b0;
   logic rst_n   = 1'b0;
   logic rs232_in = 1'b1;
   logic tbs_out;

   int checks = 0;
   int errors = 0;
   time stop_centre;

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      logic        frame;   // frame expected
      logic [15:0] halves;  // expected half-bit levels, first half in bit 15
      logic [1:0]  par;     // expected parity half-bits (parity build only)
      int          gap_bits;
   } vec_t;

   vec_t vecs [NVEC];

   tbs_tx dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .rs232_in(rs232_in),
      .TBS_out (tbs_out)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic logic exp_level(input int c, input logic [15:0] h, input logic [1:0] p);
      logic [15:0] hv;
      logic [1:0]  pv;
      hv = h;
      pv = p;
      if (c < 200) return 1'b0;
      if (c < 1000) return hv[15 - (c - 200) / HALF];
`ifdef TBS_PARITY_EN
      if (c < 1100) return pv[1 - (c - 1000) / HALF];
`endif
      return 1'b1;
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      time t0;
      t0 = $time;
      rs232_in = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 8; i++) begin
         rs232_in = d[i];
         #BIT_NS;
      end
      rs232_in = stop_bit;
      stop_centre = t0 + 9 * BIT_NS + BIT_NS / 2;
      #BIT_NS;
      rs232_in = 1'b1;
   endtask

   // bounded wait for TBS_out low, sampled on the falling clock edge
   task automatic wait_fall(input int budget, output logic seen, output time fall_t);
      seen = 1'b0;
      fall_t = 0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk_50M);
         if (tbs_out === 1'b0) begin
            seen = 1'b1;
            fall_t = $time;
         end
      end
   endtask

   // count cycles with TBS_out not high over a window
   task automatic watch_quiet(input int cycles, output int lows);
      lows = 0;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk_50M);
         if (tbs_out !== 1'b1) lows++;
      end
   endtask

   // wait for one frame and compare it cycle by cycle, plus 50 idle cycles
   task automatic watch_frame(input logic [15:0] h, input logic [1:0] p,
                              output logic seen, output time fall_t, output int bad);
      logic e;
      bad = 0;
      wait_fall(20000, seen, fall_t);
      if (seen) begin
         for (int c = 1; c < FRAME + 50; c++) begin
            @(negedge clk_50M);
            e = (c < FRAME) ? exp_level(c, h, p) : 1'b1;
            if (tbs_out !== e) bad++;
         end
      end
   endtask

   initial begin
      logic seen;
      time  fall_t;
      int   bad;
      int   lows;

      vecs[0] = '{8'h55, 1'b1, 1'b1, 16'h9999, 2'b10, 2};
      vecs[1] = '{8'hA3, 1'b1, 1'b1, 16'h66A5, 2'b10, 20};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 16'hAAAA, 2'b10, 20};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 16'h5555, 2'b10, 2};
      vecs[4] = '{8'h6B, 1'b0, 1'b0, 16'h0000, 2'b00, 2};
      vecs[5] = '{8'h0B, 1'b1, 1'b1, 16'hAA65, 2'b01, 2};
      vecs[6] = '{8'h80, 1'b1, 1'b1, 16'h6AAA, 2'b01, 2};

      // reset held for 200 ns, output must stay high throughout and after
      lows = 0;
      for (int n = 0; n < 10; n++) begin
         #19;
         if (tbs_out !== 1'b1) lows++;
      end
      #10;
      check("reset_hold", lows, 0);
      rst_n = 1'b1;
      watch_quiet(500, lows);
      check("post_reset_idle", lows, 0);

      // table-driven frames
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].frame) begin
            fork
               send_byte(vecs[i].data, vecs[i].stop);
               watch_frame(vecs[i].halves, vecs[i].par, seen, fall_t, bad);
            join
            check($sformatf("frame_seen_%02h", vecs[i].data), int'(seen), 1);
            if (seen) begin
               check_range($sformatf("latency_ns_%02h", vecs[i].data),
                           int'(fall_t - stop_centre), 0, 300);
               check($sformatf("wave_bad_cycles_%02h", vecs[i].data), bad, 0);
            end
         end else begin
            fork
               send_byte(vecs[i].data, vecs[i].stop);
               watch_quiet(6500, lows);
            join
            check($sformatf("no_frame_%02h", vecs[i].data), lows, 0);
         end
         #(vecs[i].gap_bits * BIT_NS);
      end

      // 2 us low glitch is rejected at mid start bit
      rs232_in = 1'b0;
      #2000;
      rs232_in = 1'b1;
      watch_quiet(1500, lows);
      check("glitch_rejected", lows, 0);

      // reset asserted during T_DATA forces the line high at once
      fork
         send_byte(8'h55, 1'b1);
         wait_fall(20000, seen, fall_t);
      join
      check("midrst_frame_seen", int'(seen), 1);
      repeat (310) @(negedge clk_50M);
      check("midrst_pre_level", int'(tbs_out), 0);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_async_high", int'(tbs_out), 1);
      #50;
      rst_n = 1'b1;
      watch_quiet(3000, lows);
      check("midrst_no_residual", lows, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
